// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU select decode and EX/MEM, MEM/WB operand forwarding.
// Presents OP1/OP2/Sel to the ALU under a valid/ready handshake with stall and flush.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  ALUOp,
    input  logic [5:0]  Funct,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    input  logic [31:0] Imm,
    input  logic        ALUSrc,
    input  logic        RegDst,
    input  logic        RegWrite_in,
    input  logic [4:0]  Rs,
    input  logic [4:0]  Rt,
    input  logic [4:0]  Rd,
    input  logic        flush,
    input  logic        exmem_RegWrite,
    input  logic [4:0]  exmem_Rd,
    input  logic [31:0] exmem_Resultado,
    input  logic        memwb_RegWrite,
    input  logic [4:0]  memwb_Rd,
    input  logic [31:0] memwb_Data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] OP1,
    output logic [31:0] OP2,
    output logic [3:0]  Sel,
    output logic [31:0] StoreData,
    output logic [4:0]  WriteReg,
    output logic        RegWrite_out,
    output logic        Illegal
);

    logic        valid_q;
    logic [31:0] rd1_q, rd2_q, imm_q;
    logic [4:0]  rs_q, rt_q, write_reg_q;
    logic        alu_src_q, reg_write_q, illegal_q;
    logic [3:0]  sel_q;

    logic [3:0]  sel_d;
    logic        illegal_d;
    logic        capture;
    logic [31:0] fwd_rs, fwd_rt;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sel_d     = 4'd2;
        illegal_d = 1'b0;
        unique case (ALUOp)
            2'b00: sel_d = 4'd2;
            2'b01: sel_d = 4'd6;
            2'b11: sel_d = 4'd1;
            2'b10: begin
                case (Funct)
                    6'b100000: sel_d = 4'd2;
                    6'b100010: sel_d = 4'd6;
                    6'b100100: sel_d = 4'd0;
                    6'b100101: sel_d = 4'd1;
                    6'b101010: sel_d = 4'd7;
                    6'b100111: sel_d = 4'd12;
                    default:   illegal_d = 1'b1;
                endcase
            end
            default: sel_d = 4'd2;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            write_reg_q <= '0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            sel_q       <= '0;
        end else if (capture) begin
            valid_q     <= 1'b1;
            rd1_q       <= RD1;
            rd2_q       <= RD2;
            imm_q       <= Imm;
            rs_q        <= Rs;
            rt_q        <= Rt;
            write_reg_q <= RegDst ? Rd : Rt;
            alu_src_q   <= ALUSrc;
            reg_write_q <= RegWrite_in;
            illegal_q   <= illegal_d;
            sel_q       <= sel_d;
        end else if (out_ready || flush) begin
            valid_q <= 1'b0;
        end
    end

    // EX/MEM is the younger result, so it wins when both stages target the same register.
    always_comb begin
        fwd_rs = rd1_q;
        if (exmem_RegWrite && exmem_Rd != 5'd0 && exmem_Rd == rs_q)
            fwd_rs = exmem_Resultado;
        else if (memwb_RegWrite && memwb_Rd != 5'd0 && memwb_Rd == rs_q)
            fwd_rs = memwb_Data;
    end

    always_comb begin
        fwd_rt = rd2_q;
        if (exmem_RegWrite && exmem_Rd != 5'd0 && exmem_Rd == rt_q)
            fwd_rt = exmem_Resultado;
        else if (memwb_RegWrite && memwb_Rd != 5'd0 && memwb_Rd == rt_q)
            fwd_rt = memwb_Data;
    end

    assign out_valid    = valid_q;
    assign OP1          = fwd_rs;
    assign StoreData    = fwd_rt;
    assign OP2          = alu_src_q ? imm_q : fwd_rt;
    assign Sel          = sel_q;
    assign WriteReg     = write_reg_q;
    assign RegWrite_out = reg_write_q && valid_q;
    assign Illegal      = illegal_q;

endmodule
